// File: rtl/types_pkg.sv
// Shared types for the issue stage: FU tags, entry states and table records.
package types_pkg;

  localparam int unsigned NUM_FU   = 3;
  localparam int unsigned NUM_REGS = 32;

  // FuNone doubles as the "operand ready" tag in Qj/Qk.
  typedef enum logic [1:0] {
    FuAlu    = 2'd0,
    FuLdst   = 2'd1,
    FuBranch = 2'd2,
    FuNone   = 2'd3
  } fu_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StIssued
  } fust_state_e;

  typedef struct packed {
    fust_state_e state;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    fu_t         qj;
    fu_t         qk;
  } fust_entry_t;

  typedef struct packed {
    logic busy;
    fu_t  fu;
  } rst_entry_t;

  localparam fust_entry_t FustReset = '{
    state: StIdle, instr: 32'd0, rd: 5'd0, rs: 5'd0, rt: 5'd0, qj: FuNone, qk: FuNone
  };
  localparam rst_entry_t RstReset = '{busy: 1'b0, fu: FuAlu};

endpackage

// File: rtl/issue_select.sv
// Fixed-priority issue arbiter: BRANCH over LDST over ALU.
module issue_select
  import types_pkg::*;
(
  input  logic [NUM_FU-1:0] issuable,
  input  logic [NUM_FU-1:0] fu_ready,
  output logic [NUM_FU-1:0] grant
);

  logic [NUM_FU-1:0] req;

  // One-hot grant to the highest-priority issuable entry whose FU can accept
  always_comb begin
    req   = issuable & fu_ready;
    grant = '0;
    if (req[2])      grant = 3'b100;
    else if (req[1]) grant = 3'b010;
    else if (req[0]) grant = 3'b001;
  end

endmodule

// File: rtl/issue.sv
// Issue stage: one reservation entry per FU plus a register result-status table.
module issue
  import types_pkg::*;
(
  input  logic                CLK,
  input  logic                nRST,
  input  logic                flush,
  input  logic                freeze,
  input  logic                di_valid,
  input  logic [1:0]          di_fu,
  input  logic [4:0]          di_rd,
  input  logic [4:0]          di_rs,
  input  logic [4:0]          di_rt,
  input  logic                di_regwrite,
  input  logic [31:0]         di_instr,
  input  logic [NUM_FU-1:0]   fu_ready,
  input  logic                wb_valid,
  input  logic [1:0]          wb_fu,
  output logic [NUM_FU-1:0]   fust_busy,
  output logic [NUM_REGS-1:0] rst_busy,
  output logic                is_valid,
  output logic [1:0]          is_fu,
  output logic [31:0]         is_instr,
  output logic [4:0]          is_rs,
  output logic [4:0]          is_rt
);

  fust_entry_t fust_q [NUM_FU];
  fust_entry_t fust_d [NUM_FU];
  rst_entry_t  rst_q  [NUM_REGS];
  rst_entry_t  rst_d  [NUM_REGS];

  logic [NUM_FU-1:0] issuable;
  logic [NUM_FU-1:0] grant;
  logic              wb_hit;
  logic              entry_idle;
  logic              accept;

  // A source whose producer completes this cycle is captured as ready
  function automatic fu_t src_tag(input rst_entry_t e, input logic hit, input logic [1:0] wfu);
    if (e.busy && !(hit && e.fu == fu_t'(wfu))) return e.fu;
    return FuNone;
  endfunction

  // Status views of the tables and the accept / writeback qualifiers
  always_comb begin
    wb_hit     = 1'b0;
    entry_idle = 1'b0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      fust_busy[f] = (fust_q[f].state != StIdle);
      issuable[f]  = (fust_q[f].state == StWait) && (fust_q[f].qj == FuNone) &&
                     (fust_q[f].qk == FuNone);
      if (wb_valid && wb_fu == 2'(f) && fust_q[f].state == StIssued) wb_hit = 1'b1;
      if (di_fu == 2'(f) && fust_q[f].state == StIdle) entry_idle = 1'b1;
    end
    for (int unsigned r = 0; r < NUM_REGS; r++) rst_busy[r] = rst_q[r].busy;
    accept = di_valid && !freeze && !flush && entry_idle &&
             !(di_regwrite && rst_q[di_rd].busy);
  end

  issue_select u_select (
    .issuable (issuable),
    .fu_ready (fu_ready),
    .grant    (grant)
  );

  // Issue port; flush also suppresses issue so a discarded entry is never launched
  always_comb begin
    is_valid = (|grant) && !freeze && !flush;
    is_fu    = '0;
    is_instr = '0;
    is_rs    = '0;
    is_rt    = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      if (is_valid && grant[f]) begin
        is_fu    = 2'(f);
        is_instr = fust_q[f].instr;
        is_rs    = fust_q[f].rs;
        is_rt    = fust_q[f].rt;
      end
    end
  end

  // Next state: writeback, then issue, then flush, then dispatch capture
  always_comb begin
    fust_d = fust_q;
    rst_d  = rst_q;
    if (wb_hit) begin
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        if (wb_fu == 2'(f)) fust_d[f].state = StIdle;
        if (fust_q[f].qj == fu_t'(wb_fu)) fust_d[f].qj = FuNone;
        if (fust_q[f].qk == fu_t'(wb_fu)) fust_d[f].qk = FuNone;
      end
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (rst_q[r].fu == fu_t'(wb_fu)) rst_d[r].busy = 1'b0;
      end
    end
    if (is_valid) begin
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        if (grant[f]) fust_d[f].state = StIssued;
      end
    end
    if (flush) begin
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        if (fust_q[f].state == StWait) begin
          fust_d[f].state = StIdle;
          for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (rst_q[r].busy && rst_q[r].fu == fu_t'(2'(f))) rst_d[r].busy = 1'b0;
          end
        end
      end
    end
    if (accept) begin
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        if (di_fu == 2'(f)) begin
          fust_d[f] = '{
            state: StWait, instr: di_instr, rd: di_rd, rs: di_rs, rt: di_rt,
            qj: src_tag(rst_q[di_rs], wb_hit, wb_fu),
            qk: src_tag(rst_q[di_rt], wb_hit, wb_fu)
          };
        end
      end
      if (di_regwrite && di_rd != 5'd0) rst_d[di_rd] = '{busy: 1'b1, fu: fu_t'(di_fu)};
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned f = 0; f < NUM_FU; f++) fust_q[f] <= FustReset;
      for (int unsigned r = 0; r < NUM_REGS; r++) rst_q[r] <= RstReset;
    end else begin
      fust_q <= fust_d;
      rst_q  <= rst_d;
    end
  end

endmodule

// File: tb/tb_issue.sv
// Bench for issue: directed vector table plus random traffic against a scoreboard model.
module tb_issue;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        flush, freeze, di_valid, di_regwrite, wb_valid;
  logic [1:0]  di_fu, wb_fu;
  logic [4:0]  di_rd, di_rs, di_rt;
  logic [31:0] di_instr;
  logic [2:0]  fu_ready;
  logic [2:0]  fust_busy;
  logic [31:0] rst_busy;
  logic        is_valid;
  logic [1:0]  is_fu;
  logic [31:0] is_instr;
  logic [4:0]  is_rs, is_rt;

  issue dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .flush       (flush),
    .freeze      (freeze),
    .di_valid    (di_valid),
    .di_fu       (di_fu),
    .di_rd       (di_rd),
    .di_rs       (di_rs),
    .di_rt       (di_rt),
    .di_regwrite (di_regwrite),
    .di_instr    (di_instr),
    .fu_ready    (fu_ready),
    .wb_valid    (wb_valid),
    .wb_fu       (wb_fu),
    .fust_busy   (fust_busy),
    .rst_busy    (rst_busy),
    .is_valid    (is_valid),
    .is_fu       (is_fu),
    .is_instr    (is_instr),
    .is_rs       (is_rs),
    .is_rt       (is_rt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Scoreboard model: entry status (0 free, 1 waiting, 2 launched), outstanding
  // producer per source (-1 none), and pending producer per register (-1 none).
  int          m_st [3];
  int          m_dj [3];
  int          m_dk [3];
  logic [31:0] m_instr [3];
  logic [4:0]  m_rs [3];
  logic [4:0]  m_rt [3];
  int          m_prod [32];
  int          m_pick;
  logic        e_v;
  logic [1:0]  e_fu;
  logic [31:0] e_instr;
  logic [4:0]  e_rs, e_rt;
  logic [2:0]  e_busy;
  logic [31:0] e_rst;

  typedef struct {
    logic        fl, fz, dv;
    logic [1:0]  fu;
    logic [4:0]  rd, rs, rt;
    logic        rw;
    logic [2:0]  rdy;
    logic        wbv;
    logic [1:0]  wbf;
    logic        ev;
    logic [1:0]  efu;
    logic [2:0]  eb;
    logic [31:0] er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int fl, fz, dv, fu, rd, rs, rt, rw, rdy, wbv, wbf,
                              ev, efu, eb, er);
    vec_t v;
    v.fl = fl[0]; v.fz = fz[0]; v.dv = dv[0]; v.fu = fu[1:0];
    v.rd = rd[4:0]; v.rs = rs[4:0]; v.rt = rt[4:0]; v.rw = rw[0];
    v.rdy = rdy[2:0]; v.wbv = wbv[0]; v.wbf = wbf[1:0];
    v.ev = ev[0]; v.efu = efu[1:0]; v.eb = eb[2:0]; v.er = 32'(er);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int f = 0; f < 3; f++) begin
      m_st[f] = 0; m_dj[f] = -1; m_dk[f] = -1;
      m_instr[f] = '0; m_rs[f] = '0; m_rt[f] = '0;
    end
    for (int r = 0; r < 32; r++) m_prod[r] = -1;
  endtask

  task automatic model_eval();
    m_pick = -1;
    for (int f = 2; f >= 0; f--) begin
      if (m_pick < 0 && m_st[f] == 1 && m_dj[f] < 0 && m_dk[f] < 0 && fu_ready[f]) m_pick = f;
    end
    e_v = (m_pick >= 0) && !freeze && !flush;
    e_fu = '0; e_instr = '0; e_rs = '0; e_rt = '0;
    if (e_v) begin
      e_fu = 2'(m_pick); e_instr = m_instr[m_pick]; e_rs = m_rs[m_pick]; e_rt = m_rt[m_pick];
    end
    for (int f = 0; f < 3; f++) e_busy[f] = (m_st[f] != 0);
    for (int r = 0; r < 32; r++) e_rst[r] = (m_prod[r] >= 0);
  endtask

  task automatic model_update();
    int old_st [3];
    int wf, df;
    logic acc;
    for (int f = 0; f < 3; f++) old_st[f] = m_st[f];
    wf = int'(wb_fu);
    df = int'(di_fu);
    if (wb_valid && wf < 3) begin
      if (m_st[wf] == 2) begin
        m_st[wf] = 0;
        for (int r = 0; r < 32; r++) if (m_prod[r] == wf) m_prod[r] = -1;
        for (int f = 0; f < 3; f++) begin
          if (m_dj[f] == wf) m_dj[f] = -1;
          if (m_dk[f] == wf) m_dk[f] = -1;
        end
      end
    end
    if (e_v) m_st[m_pick] = 2;
    if (flush) begin
      for (int f = 0; f < 3; f++) begin
        if (old_st[f] == 1) begin
          m_st[f] = 0;
          for (int r = 0; r < 32; r++) if (m_prod[r] == f) m_prod[r] = -1;
        end
      end
    end
    acc = di_valid && !freeze && !flush && df < 3;
    if (acc) acc = (old_st[df] == 0) && !(di_regwrite && e_rst[di_rd]);
    if (acc) begin
      m_st[df] = 1;
      m_dj[df] = m_prod[di_rs];
      m_dk[df] = m_prod[di_rt];
      m_instr[df] = di_instr; m_rs[df] = di_rs; m_rt[df] = di_rt;
      if (di_regwrite && di_rd != 5'd0) m_prod[di_rd] = df;
    end
  endtask

  // Compare every output against the model, then advance the model one edge
  task automatic check_model();
    model_eval();
    chk("is_valid", 32'(is_valid), 32'(e_v));
    chk("is_fu", 32'(is_fu), 32'(e_fu));
    chk("is_instr", is_instr, e_instr);
    chk("is_rs", 32'(is_rs), 32'(e_rs));
    chk("is_rt", 32'(is_rt), 32'(e_rt));
    chk("fust_busy", 32'(fust_busy), 32'(e_busy));
    chk("rst_busy", rst_busy, e_rst);
    model_update();
  endtask

  task automatic idle_inputs();
    flush = 0; freeze = 0; di_valid = 0; di_fu = 0; di_rd = 0; di_rs = 0; di_rt = 0;
    di_regwrite = 0; di_instr = 0; fu_ready = 0; wb_valid = 0; wb_fu = 0;
  endtask

  task automatic drive_random();
    int cand [$];
    flush       = ($urandom_range(0, 19) == 0);
    freeze      = ($urandom_range(0, 9) == 0);
    di_valid    = ($urandom_range(0, 9) < 6);
    di_fu       = 2'($urandom_range(0, 3));
    di_rd       = 5'($urandom_range(0, 7));
    di_rs       = 5'($urandom_range(0, 7));
    di_rt       = 5'($urandom_range(0, 7));
    di_regwrite = 1'($urandom_range(0, 1));
    di_instr    = $urandom;
    fu_ready    = 3'($urandom_range(0, 7));
    for (int f = 0; f < 3; f++) if (m_st[f] == 2) cand.push_back(f);
    if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
      wb_valid = 1'b1;
      wb_fu    = 2'(cand[$urandom_range(0, cand.size() - 1)]);
    end else begin
      wb_valid = ($urandom_range(0, 9) == 0);
      wb_fu    = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    idle_inputs();
    nRST = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    #2;
    chk("reset is_valid", 32'(is_valid), 32'd0);
    chk("reset fust_busy", 32'(fust_busy), 32'd0);
    chk("reset rst_busy", rst_busy, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // fl fz dv fu rd rs rt rw rdy wbv wbf | ev efu eb er
    tbl.push_back(mk(0,0,1,0, 5,1,2,1,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 1,0,1,32'h20));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,1,0, 0,0,1,32'h20));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,1, 7,3,4,1,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 8,7,1,1,7,0,0, 1,1,2,32'h80));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 0,0,3,32'h180));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,1,1, 0,0,3,32'h180));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 1,0,1,32'h100));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,1,0, 0,0,1,32'h100));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,1, 7,0,0,1,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 1,1,2,32'h80));
    tbl.push_back(mk(0,0,1,0, 8,7,7,1,7,1,1, 0,0,2,32'h80));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 1,0,1,32'h100));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,1,0, 0,0,1,32'h100));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 1,0,0,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,2, 0,0,0,0,0,0,0, 0,0,1,32'h2));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 1,2,5,32'h2));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 1,0,5,32'h2));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,1,2, 0,0,5,32'h2));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,1,0, 0,0,1,32'h2));
    tbl.push_back(mk(0,0,1,0, 1,0,0,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,2, 0,0,0,0,0,0,0, 0,0,1,32'h2));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,3,0,0, 1,0,5,32'h2));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 1,2,5,32'h2));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,1,0, 0,0,5,32'h2));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,1,2, 0,0,4,32'h0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,1, 9,0,0,1,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0,10,9,0,1,7,0,0, 1,1,2,32'h200));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,7,0,0, 0,0,3,32'h600));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 0,0,2,32'h200));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,1,1, 0,0,2,32'h200));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 0,1,2,1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,0,0,0, 0,0,1,0));
    tbl.push_back(mk(0,0,1,0, 3,4,5,1,0,0,0, 0,0,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 1,0,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,1,0, 0,0,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 4,0,0,1,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 4,0,0,1,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,7,0,0, 0,0,1,32'h10));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 1,0,1,32'h10));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,7,1,0, 0,0,1,32'h10));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,7,0,0, 0,0,0,0));

    foreach (tbl[i]) begin
      flush = tbl[i].fl; freeze = tbl[i].fz; di_valid = tbl[i].dv; di_fu = tbl[i].fu;
      di_rd = tbl[i].rd; di_rs = tbl[i].rs; di_rt = tbl[i].rt; di_regwrite = tbl[i].rw;
      di_instr = 32'hC000_0000 + 32'(i); fu_ready = tbl[i].rdy;
      wb_valid = tbl[i].wbv; wb_fu = tbl[i].wbf;
      #2;
      chk($sformatf("vec%0d is_valid", i), 32'(is_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d is_fu", i), 32'(is_fu), 32'(tbl[i].efu));
      chk($sformatf("vec%0d fust_busy", i), 32'(fust_busy), 32'(tbl[i].eb));
      chk($sformatf("vec%0d rst_busy", i), rst_busy, tbl[i].er);
      check_model();
      @(negedge CLK);
    end

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        // Asynchronous reset mid-traffic: outputs must clear without a clock edge
        idle_inputs();
        #2;
        nRST = 1'b0;
        #1;
        chk("async reset is_valid", 32'(is_valid), 32'd0);
        chk("async reset fust_busy", 32'(fust_busy), 32'd0);
        chk("async reset rst_busy", rst_busy, 32'd0);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
      end
      drive_random();
      #2;
      check_model();
      @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue.md
ISSUE -- requirements
Module: issue

Interface
REQ-001 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port nRST  input  1  asynchronous active-low reset.
REQ-003 SHALL have port flush  input  1  discard all not-yet-issued work.
REQ-004 SHALL have port freeze  input  1  stall: no accept, no issue.
REQ-005 SHALL have port di_valid  input  1  dispatch packet valid (dispatch already cleared hazards).
REQ-006 SHALL have ports di_fu (2, fu_t: ALU=0, LDST=1, BRANCH=2, NONE=3), di_rd/di_rs/di_rt (5 each), di_regwrite (1), di_instr (32), all inputs: dispatch packet fields.
REQ-007 SHALL have port fu_ready  input  3  per-FU accept, indexed by fu_t.
REQ-008 SHALL have ports wb_valid (1) and wb_fu (2), inputs: completion from the named FU.
REQ-009 SHALL have port fust_busy  output  3  per-FU entry occupied; feeds dispatch structural-hazard check.
REQ-010 SHALL have port rst_busy  output  32  per-register pending write; feeds dispatch WAW check.
REQ-011 SHALL have ports is_valid (1), is_fu (2), is_instr (32), is_rs (5), is_rt (5), outputs: the issue port.

Function
REQ-012 SHALL keep one entry per FU, states IDLE, WAIT, ISSUED; fust_busy[f] = (state != IDLE).
REQ-013 SHALL keep per register rst_busy bit and 2-bit producer tag rst_fu.
REQ-014 SHALL accept a packet when di_valid & ~freeze & ~flush & di_fu != NONE & entry IDLE & ~(di_regwrite & rst_busy[di_rd]); otherwise it is dropped with no state change.
REQ-015 SHALL on accept latch instr, rd, rs, rt and Qj/Qk = producer tag of rs/rt if busy (read before this packet's rd update), else "ready"; entry goes to WAIT next cycle.
REQ-016 SHALL on accept with di_regwrite and di_rd != 0 set rst_busy[di_rd] and rst_fu[di_rd] = di_fu; register 0 is never marked busy.
REQ-017 SHALL treat an entry as issuable when in WAIT with Qj and Qk ready, from the cycle after accept (1-cycle dispatch-to-issue latency minimum).
REQ-018 SHALL combinationally select among issuable entries with fu_ready set, priority BRANCH > LDST > ALU; is_valid=0 when none or freeze=1.
REQ-019 SHALL move the selected entry WAIT -> ISSUED on the edge where is_valid=1; one issue per cycle.
REQ-020 SHALL on wb_valid with entry wb_fu in ISSUED: return entry to IDLE, clear rst_busy[r] for every r with rst_fu[r]==wb_fu, set any Qj/Qk equal to wb_fu to ready; wb to a non-ISSUED entry is ignored.
REQ-021 SHALL apply writeback before dispatch operand capture in the same cycle: a source produced by the completing FU is captured as ready.
REQ-022 SHALL process writeback during freeze and during flush.
REQ-023 SHALL on flush return all WAIT entries to IDLE and clear their rst bits; ISSUED entries remain until writeback.
REQ-024 SHALL hold is_fu/is_instr/is_rs/is_rt at 0 when is_valid=0.

Reset
REQ-025 SHALL on nRST low, asynchronously, set all entries IDLE, all Qj/Qk ready, rst_busy=0, rst_fu=0, hence fust_busy=0 and is_valid=0; in-flight work is abandoned.
REQ-026 SHALL accept a packet on the first rising edge after nRST deasserts.

Structure
REQ-027 SHALL take fu_t, NUM_FU=3, NUM_REGS=32, entry state enum, fust_entry_t and rst_entry_t from types_pkg.
REQ-028 SHALL place the priority selection in sub-module issue_select (issuable mask and fu_ready in, one-hot grant out).

Verification
REQ-029 SHALL cover: reset, ALU add rd=5 rs=1 rt=2, all ready -> is_valid with is_fu=ALU one cycle later, fust_busy=001, rst_busy[5]=1; wb ALU -> both cleared next cycle.
REQ-030 SHALL cover RAW: LDST writes r7, then ALU reads rs=7 -> ALU waits in WAIT; wb LDST -> ALU issues the following cycle.
REQ-031 SHALL cover same-cycle wb LDST and accept of ALU reading r7 -> ALU issues the next cycle.
REQ-032 SHALL cover ALU and BRANCH both issuable, fu_ready=111 -> BRANCH first, ALU next cycle; fu_ready[2]=0 -> ALU first.
REQ-033 SHALL cover flush with ALU in WAIT on r9 and LDST ISSUED writing r9 -> ALU entry IDLE; rst_busy[9] stays 1 until wb LDST.
REQ-034 SHALL cover dispatch with di_rd=0 -> rst_busy stays 0; packet to busy FU -> dropped, entry contents unchanged.
